pool_relu_stream: RTL and testbench
===================================

Name: pool_relu_stream

Overview:
- Streaming 2x2/stride-2 max-pool with ReLU for one convolution feature map, fed in raster order by a valid/ready pixel stream.
- Sits downstream of the convolution stage; one instance per channel, 24x24 in -> 12x12 out at defaults.
- Holds only one row of partial maxima (IN_W/2 entries), never a full frame.

Parameters:
- IN_W, 24, input row width in pixels; must be even, >= 2.
- IN_H, 24, input rows per frame; must be even, >= 2.
- DW, 45, signed data width of input and output samples.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept input beat
- in_data  in  DW  signed conv sample, raster order (row-major, col fastest)
- in_last  in  1  marks final pixel of frame
- out_valid  out  1  pooled sample valid
- out_ready  in  1  downstream accepts pooled sample
- out_data  out  DW  pooled, ReLU'd sample (always >= 0, MSB 0)
- out_last  out  1  marks final pooled sample of frame
- frame_err  out  1  one-cycle pulse on in_last framing mismatch

Behaviour:
- Reset (synchronous, priority over all else): out_valid=0, out_data=0, out_last=0, frame_err=0, row/col counters=0, hold register=0. Line buffer contents don't care. Reset mid-frame discards all partial state; next accepted beat is treated as pixel (0,0).
- in_ready = !out_valid || out_ready (combinational). Beat accepted when in_valid && in_ready. Output accepted when out_valid && out_ready.
- On accepted beat at (row, col), with k = col>>1, comparisons signed:
  - row even, col even: hold <= in_data.
  - row even, col odd: linebuf[k] <= max(hold, in_data).
  - row odd, col even: hold <= max(linebuf[k], in_data).
  - row odd, col odd: out_data <= relu(max(hold, in_data)), out_valid <= 1, out_last <= (row==IN_H-1 && col==IN_W-1).
- relu(v) = 0 if v < 0, else v. Equal values: either operand, same result.
- Latency: out_valid rises the cycle after the accepted beat that completes a window. Max output rate is one per two input beats; single output register, no FIFO.
- out_valid clears on output accept, unless a new window completes in the same cycle, in which case out_valid stays 1 with the new data. Output register must not change while out_valid && !out_ready.
- Counters: col increments per accepted beat; at IN_W-1 it wraps to 0 and row increments; at (IN_H-1, IN_W-1) both wrap to 0.
- Framing:
  - in_last on a beat that is not (IN_H-1, IN_W-1): frame_err pulses the next cycle. The beat is still processed normally (it may complete a window). Counters then force to 0.
  - Final position accepted without in_last: frame_err pulses the next cycle and counters wrap normally.
  - frame_err is 0 in all other cycles.
- No in_valid: state holds. in_valid may drop mid-frame indefinitely.

Test Plan:
- IN_W=IN_H=4, frame 0..15 ascending, out_ready=1 -> outputs 5,7,13,15; out_last only on 15; each out_valid 1 cycle after beat 5/7/13/15.
- IN_W=IN_H=4, all inputs -3 except pixel (1,1)=-1 -> outputs 0,0,0,0 (ReLU clamps); then pixel (2,3)=+9 in next frame -> third output 0, fourth output 9.
- Defaults 24x24, random signed 45-bit data incl. max-negative/max-positive, random in_valid/out_ready gaps -> 144 outputs matching golden model; out_last only on the 144th; out_data stable while stalled.
- Backpressure: hold out_ready=0 after first output -> in_ready=0 from the next cycle, no beats lost; release -> stream resumes, values correct.
- in_last on pixel 9 of a 4x4 frame -> frame_err pulse 1 cycle; next frame 0..15 pools correctly to 5,7,13,15.
- rst asserted after 6 beats -> all outputs 0 next cycle; fresh full frame yields correct results with no residue.

Source files
------------

// File: rtl/pool_relu_stream_if.sv
// Stream bundle for pool_relu_stream: one input pixel stream and one pooled
// output stream, each valid/ready, plus the framing-error pulse.
//   in_valid/in_ready/in_data/in_last     : conv samples, raster order
//   out_valid/out_ready/out_data/out_last : pooled, ReLU'd samples
//   frame_err                             : one-cycle pulse on a framing mismatch
// modport slave is the pooling block; modport master is whoever feeds it and
// drains its output.
interface pool_relu_stream_if #(
  parameter int DW = 45
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_last;
  logic                 frame_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, frame_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, frame_err
  );
endinterface

// File: rtl/pool_relu_stream.sv
// Streaming 2x2 / stride-2 max-pool followed by ReLU for one feature-map
// channel. Pixels arrive in raster order; only one row of partial maxima
// (IN_W/2 entries) is stored, never a full frame.
//   clk, rst : clock, synchronous active-high reset
//   s        : pool_relu_stream_if.slave (input stream, output stream,
//              frame_err pulse)
// A window completes on the odd-row/odd-col pixel; the pooled result lands in
// a single output register the following cycle. Input is stalled while that
// register holds an unaccepted result.
module pool_relu_stream #(
  parameter int IN_W = 24,
  parameter int IN_H = 24,
  parameter int DW   = 45
) (
  input  logic              clk,
  input  logic              rst,
  pool_relu_stream_if.slave s
);
  localparam int CW = $clog2(IN_W);
  localparam int RW = $clog2(IN_H);
  localparam int KW = (IN_W / 2 > 1) ? $clog2(IN_W / 2) : 1;
  localparam logic [CW-1:0] COL_END = CW'(IN_W - 1);
  localparam logic [RW-1:0] ROW_END = RW'(IN_H - 1);

  function automatic logic signed [DW-1:0] max_s(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] v);
    return v[DW-1] ? '0 : v;
  endfunction

  logic signed [DW-1:0] linebuf [IN_W/2];
  logic signed [DW-1:0] hold_p0;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [KW-1:0]        k;

  logic                 vld_p1;
  logic signed [DW-1:0] data_p1;
  logic                 last_p1;
  logic                 err_p1;

  logic                 accept;
  logic                 out_acc;
  logic                 at_end;
  logic signed [DW-1:0] pair_p0;
  logic signed [DW-1:0] max_p0;

  // Stage 0: beat decode and running maximum for the current window
  assign s.in_ready = !vld_p1 || s.out_ready;
  assign accept     = s.in_valid && s.in_ready;
  assign out_acc    = vld_p1 && s.out_ready;
  assign at_end     = (row == ROW_END) && (col == COL_END);
  assign k          = KW'(col >> 1);

  // Odd columns pair with the hold register (left neighbour of this window);
  // even columns on odd rows pair with the upper row's partial maximum.
  assign pair_p0 = col[0] ? hold_p0 : linebuf[k];
  assign max_p0  = max_s(pair_p0, s.in_data);

  always_ff @(posedge clk) begin
    if (accept && !row[0] && col[0]) begin
      linebuf[k] <= max_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_p0 <= '0;
      col     <= '0;
      row     <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      err_p1 <= accept && (s.in_last != at_end);

      if (accept && !col[0]) begin
        hold_p0 <= row[0] ? max_p0 : s.in_data;
      end

      // Stage 1: pooled output register; a completing window overrides the
      // clear from a same-cycle output accept.
      if (accept && row[0] && col[0]) begin
        vld_p1  <= 1'b1;
        data_p1 <= relu(max_p0);
        last_p1 <= at_end;
      end else if (out_acc) begin
        vld_p1 <= 1'b0;
      end

      // An early in_last restarts the frame after this beat is processed.
      if (accept) begin
        if (s.in_last && !at_end) begin
          col <= '0;
          row <= '0;
        end else if (col == COL_END) begin
          col <= '0;
          row <= (row == ROW_END) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign s.out_valid = vld_p1;
  assign s.out_data  = data_p1;
  assign s.out_last  = last_p1;
  assign s.frame_err = err_p1;
endmodule

// File: tb/tb_pool_relu_stream.sv
module tb_pool_relu_stream;
  localparam int DW = 45;
  typedef logic signed [DW-1:0] smp_t;
  typedef struct packed { logic [DW-1:0] d; logic l; } exp_t;
  typedef struct packed { logic [15:0][7:0] pix; logic [3:0][7:0] exp; } vec_t;

  logic clk;
  logic rst4, rst24;
  int   tests = 0;
  int   fails = 0;

  pool_relu_stream_if #(.DW(DW)) i4 ();
  pool_relu_stream_if #(.DW(DW)) i24 ();

  pool_relu_stream #(.IN_W(4), .IN_H(4), .DW(DW)) d4 (.clk(clk), .rst(rst4), .s(i4.slave));
  pool_relu_stream #(.DW(DW)) d24 (.clk(clk), .rst(rst24), .s(i24.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic smp_t sx8(input logic [7:0] b);
    return {{(DW-8){b[7]}}, b};
  endfunction

  vec_t vecs [5];
  byte  mix [16];
  exp_t q4 [$];
  exp_t q24 [$];
  exp_t e4, e24, p24;
  smp_t f24 [576];
  smp_t wm;
  logic run24 = 1'b0;
  logic stall24 = 1'b0;
  smp_t stall_d;
  int   n24 = 0;

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (!rst4 && i4.out_valid && i4.out_ready) begin
      if (q4.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL d4_unexpected_out: got data 0x%0h, expected no output", i4.out_data);
      end else begin
        e4 = q4.pop_front();
        chk("d4_out_data", i4.out_data, smp_t'(e4.d));
        chk("d4_out_last", i4.out_last, e4.l);
      end
    end
  end

  always @(negedge clk) begin
    if (run24) begin
      chk("d24_frame_err", i24.frame_err, 0);
      if (stall24) begin
        chk("d24_stall_vld", i24.out_valid, 1);
        chk("d24_stall_data", i24.out_data, stall_d);
      end
      stall24 <= i24.out_valid && !i24.out_ready;
      stall_d <= i24.out_data;
      if (i24.out_valid && i24.out_ready) begin
        n24++;
        if (q24.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL d24_unexpected_out: got data 0x%0h, expected no output", i24.out_data);
        end else begin
          p24 = q24.pop_front();
          chk("d24_out_data", i24.out_data, smp_t'(p24.d));
          chk("d24_out_last", i24.out_last, p24.l);
        end
      end
    end
  end

  initial begin
    i24.out_ready = 1'b1;
    wait (run24);
    forever begin
      @(posedge clk);
      #1;
      i24.out_ready = run24 ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- drivers ----------------
  task automatic send4(input smp_t d, input logic l);
    int n;
    n = 0;
    i4.in_valid = 1'b1;
    i4.in_data  = d;
    i4.in_last  = l;
    @(negedge clk);
    while (!i4.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL d4_in_ready_timeout: got in_ready 0 for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
    i4.in_valid = 1'b0;
    i4.in_last  = 1'b0;
  endtask

  task automatic send24(input smp_t d, input logic l);
    int n;
    n = 0;
    i24.in_valid = 1'b1;
    i24.in_data  = d;
    i24.in_last  = l;
    @(negedge clk);
    while (!i24.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL d24_in_ready_timeout: got in_ready 0 for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
    i24.in_valid = 1'b0;
    i24.in_last  = 1'b0;
  endtask

  task automatic beat4(input int v, input int i, input logic l);
    int   r, c;
    exp_t e;
    r = i / 4;
    c = i % 4;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      e.d = sx8(vecs[v].exp[(r / 2) * 2 + c / 2]);
      e.l = (i == 15);
      q4.push_back(e);
    end
    send4(sx8(vecs[v].pix[i]), l);
  endtask

  task automatic drain4();
    int n;
    n = 0;
    while (q4.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (q4.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL d4_drain: got %0d outputs outstanding, expected 0", q4.size());
      q4.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame4(input int v, input logic with_last);
    for (int i = 0; i < 16; i++) begin
      beat4(v, i, with_last && (i == 15));
      chk("d4_vld_latency", i4.out_valid, ((i / 4) % 2 == 1) && ((i % 4) % 2 == 1));
      chk("d4_frame_err", i4.frame_err, !with_last && (i == 15));
    end
    drain4();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    mix = '{-128, 127, -5, -6, 3, -1, -7, -100, -50, -60, 20, -20, -70, -2, 0, 1};
    for (int i = 0; i < 16; i++) begin
      vecs[0].pix[i] = 8'(i);
      vecs[1].pix[i] = 8'hFD;
      vecs[2].pix[i] = 8'hFD;
      vecs[3].pix[i] = 8'(15 - i);
      vecs[4].pix[i] = 8'(mix[i]);
    end
    vecs[1].pix[5]  = 8'hFF;
    vecs[2].pix[11] = 8'd9;
    vecs[0].exp = {8'd15, 8'd13, 8'd7, 8'd5};
    vecs[1].exp = {8'd0, 8'd0, 8'd0, 8'd0};
    vecs[2].exp = {8'd9, 8'd0, 8'd0, 8'd0};
    vecs[3].exp = {8'd5, 8'd7, 8'd13, 8'd15};
    vecs[4].exp = {8'd20, 8'd0, 8'd0, 8'd127};

    i4.in_valid = 1'b0; i4.in_data = '0; i4.in_last = 1'b0; i4.out_ready = 1'b1;
    i24.in_valid = 1'b0; i24.in_data = '0; i24.in_last = 1'b0;
    rst4 = 1'b1;
    rst24 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_d4_out_valid", i4.out_valid, 0);
    chk("rst_d4_out_data", i4.out_data, 0);
    chk("rst_d4_out_last", i4.out_last, 0);
    chk("rst_d4_frame_err", i4.frame_err, 0);
    chk("rst_d4_in_ready", i4.in_ready, 1);
    chk("rst_d24_out_valid", i24.out_valid, 0);
    chk("rst_d24_out_data", i24.out_data, 0);
    chk("rst_d24_frame_err", i24.frame_err, 0);
    rst4 = 1'b0;
    rst24 = 1'b0;

    for (int v = 0; v < 5; v++) run_frame4(v, 1'b1);

    // early in_last on pixel 9
    for (int i = 0; i < 10; i++) beat4(0, i, i == 9);
    chk("early_last_err_pulse", i4.frame_err, 1);
    @(posedge clk);
    #1;
    chk("early_last_err_clear", i4.frame_err, 0);
    drain4();
    run_frame4(0, 1'b1);

    // final pixel without in_last, then a clean frame
    run_frame4(0, 1'b0);
    run_frame4(3, 1'b1);

    // backpressure after the first output
    i4.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) beat4(0, i, 1'b0);
    chk("bp_in_ready", i4.in_ready, 0);
    chk("bp_out_valid", i4.out_valid, 1);
    chk("bp_out_data", i4.out_data, 5);
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("bp_hold_in_ready", i4.in_ready, 0);
      chk("bp_hold_out_valid", i4.out_valid, 1);
      chk("bp_hold_out_data", i4.out_data, 5);
    end
    i4.out_ready = 1'b1;
    for (int i = 6; i < 16; i++) beat4(0, i, i == 15);
    drain4();

    // reset mid-frame with a result held in the output register
    i4.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) beat4(0, i, 1'b0);
    rst4 = 1'b1;
    @(posedge clk);
    #1;
    q4.delete();
    chk("midrst_out_valid", i4.out_valid, 0);
    chk("midrst_out_data", i4.out_data, 0);
    chk("midrst_out_last", i4.out_last, 0);
    chk("midrst_frame_err", i4.frame_err, 0);
    chk("midrst_in_ready", i4.in_ready, 1);
    rst4 = 1'b0;
    i4.out_ready = 1'b1;
    run_frame4(4, 1'b1);

    // 24x24 random frame with gaps and random backpressure
    for (int i = 0; i < 576; i++) begin
      case ($urandom_range(0, 9))
        0: f24[i] = {1'b1, {(DW-1){1'b0}}};
        1: f24[i] = {1'b0, {(DW-1){1'b1}}};
        2: f24[i] = '1;
        default: f24[i] = smp_t'({$urandom(), $urandom()});
      endcase
    end
    f24[0]  = {1'b1, {(DW-1){1'b0}}};
    f24[1]  = {1'b1, {(DW-1){1'b0}}};
    f24[24] = {1'b1, {(DW-1){1'b0}}};
    f24[25] = {1'b1, {(DW-1){1'b0}}};
    f24[2]  = {1'b0, {(DW-1){1'b1}}};
    run24 = 1'b1;
    for (int i = 0; i < 576; i++) begin
      int r, c;
      r = i / 24;
      c = i % 24;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        wm = f24[(r-1)*24 + c-1];
        if (f24[(r-1)*24 + c] > wm) wm = f24[(r-1)*24 + c];
        if (f24[r*24 + c-1] > wm)   wm = f24[r*24 + c-1];
        if (f24[r*24 + c] > wm)     wm = f24[r*24 + c];
        if (wm < 0) wm = '0;
        e24.d = wm;
        e24.l = (i == 575);
        q24.push_back(e24);
      end
      send24(f24[i], i == 575);
    end
    begin
      int n;
      n = 0;
      while (q24.size() != 0 && n < 500) begin
        @(posedge clk);
        n++;
      end
    end
    @(posedge clk);
    #1;
    run24 = 1'b0;
    chk("d24_output_count", n24, 144);
    chk("d24_queue_empty", q24.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
